// File: rtl/axis_tag_sched.sv
// -----------------------------------------------------------------------------
// axis_tag_sched
//
// Round-robin burst scheduler in front of the shared complex-magnitude
// datapath. NUM_TAGS AXI-stream requesters compete for one output stream.
// The winner holds the grant for up to BURST_LEN beats. After that, the grant
// moves to the next requesting tag in cyclic order. Each forwarded beat passes
// through a single output register and carries a one-hot source tag on tuser.
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset (release synchronous to clk)
//   tag_enable     per-tag enable mask; a disabled tag is never granted
//   s_axis_tvalid  per-tag valid
//   s_axis_tready  per-tag ready; at most one bit high (the granted tag)
//   s_axis_tdata   packed per-tag data; tag i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_tvalid  output valid (registered)
//   m_axis_tready  output ready
//   m_axis_tdata   output data (registered)
//   m_axis_tuser   one-hot source tag of the current output beat
//   m_axis_tlast   set on the BURST_LEN-th beat of a grant
//   grant_tag      one-hot current grant; all zero while idle
//
// Cycle behaviour
//   IDLE  : one arbitration cycle. No tready is raised.
//   BURST : beats of the granted tag move into the output register whenever
//           that register is empty or draining. The burst ends on the
//           BURST_LEN-th beat. It also ends early when the output can take a
//           beat but the granted tag has no valid beat or has been disabled.
// -----------------------------------------------------------------------------
module axis_tag_sched #(
   parameter int NUM_TAGS   = 20,
   parameter int DATA_WIDTH = 256,
   parameter int BURST_LEN  = 4     // legal range 1..256
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_TAGS-1:0]            tag_enable,
   input  logic [NUM_TAGS-1:0]            s_axis_tvalid,
   output logic [NUM_TAGS-1:0]            s_axis_tready,
   input  logic [NUM_TAGS*DATA_WIDTH-1:0] s_axis_tdata,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic [DATA_WIDTH-1:0]          m_axis_tdata,
   output logic [NUM_TAGS-1:0]            m_axis_tuser,
   output logic                           m_axis_tlast,
   output logic [NUM_TAGS-1:0]            grant_tag
);

   // --------------------------------------------------------------------------
   // Local constants
   // --------------------------------------------------------------------------
   localparam int PTR_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
   localparam int CNT_W = $clog2(BURST_LEN) + 1;

   localparam int unsigned     NT_U     = NUM_TAGS;
   localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_TAGS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
   localparam logic [NUM_TAGS-1:0] TAG_ONE = NUM_TAGS'(1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [0:0]       state;
   logic [PTR_W-1:0] ptr;       // last granted tag; it is also the live grant during BURST
   logic [CNT_W-1:0] cnt;       // beats accepted in the current burst

   // --------------------------------------------------------------------------
   // Combinational helpers
   // --------------------------------------------------------------------------
   logic [NUM_TAGS-1:0]   req;
   logic                  req_any;
   logic [PTR_W-1:0]      next_idx;
   logic                  out_ready;
   logic                  g_valid;
   logic                  g_enable;
   logic                  accept;
   logic                  early_end;
   logic                  last_beat;
   logic [DATA_WIDTH-1:0] g_data;

   // Index reached by stepping 'step' positions forward from 'base', with
   // wrap-around past NUM_TAGS-1. 'base' is always below NUM_TAGS and 'step'
   // is never above NUM_TAGS, so one subtraction is enough for the wrap.
   function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                 input int unsigned      step);
      int unsigned sum;
      sum = int'(base) + step;
      if (sum >= NT_U) sum = sum - NT_U;
      return PTR_W'(sum);
   endfunction

   assign req       = s_axis_tvalid & tag_enable;
   assign out_ready = !m_axis_tvalid || m_axis_tready;

   // Cyclic priority search starting at ptr+1. The loop runs from the farthest
   // candidate down to the nearest one. The nearest requester is written last,
   // so it wins without a separate 'found' flag.
   always_comb begin
      // NOTE: every variable assigned in a combinational block gets a default
      // first; a path that leaves one unassigned would infer a latch.
      next_idx = ptr;
      req_any  = 1'b0;
      for (int k = NUM_TAGS; k >= 1; k--) begin
         if (req[wrap_idx(ptr, k)]) begin
            next_idx = wrap_idx(ptr, k);
            req_any  = 1'b1;
         end
      end
   end

   // Signals of the granted tag. ptr equals the granted index throughout BURST.
   assign g_valid  = s_axis_tvalid[ptr];
   assign g_enable = tag_enable[ptr];

   // Data mux for the granted tag. The part-selects use constant indices,
   // which keeps the mux obvious to synthesis.
   always_comb begin
      g_data = '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         if (ptr == PTR_W'(i)) g_data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Ready goes back only to the granted tag. It depends combinationally on
   // m_axis_tready, so a draining output register can refill in the same cycle.
   always_comb begin
      s_axis_tready = '0;
      if (state == ST_BURST) s_axis_tready[ptr] = out_ready && g_enable;
   end

   assign accept    = (state == ST_BURST) && g_valid && g_enable && out_ready;
   // Early end is evaluated only when the output can move. While stalled, a
   // dropped valid cannot end the burst.
   assign early_end = (state == ST_BURST) && out_ready && (!g_valid || !g_enable);
   assign last_beat = (cnt == CNT_LAST);

   // --------------------------------------------------------------------------
   // Arbitration and burst control
   // --------------------------------------------------------------------------
   // NOTE: sequential state is assigned with non-blocking (<=) so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         ptr       <= PTR_RST;          // tag 0 gets first priority after reset
         cnt       <= '0;
         grant_tag <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_any) begin
                  state     <= ST_BURST;
                  ptr       <= next_idx;
                  cnt       <= '0;
                  grant_tag <= TAG_ONE << next_idx;
               end
            end
            ST_BURST: begin
               if (accept) begin
                  cnt <= cnt + 1'b1;
                  if (last_beat) begin
                     state     <= ST_IDLE;
                     grant_tag <= '0;
                  end
               end else if (early_end) begin
                  state     <= ST_IDLE;
                  grant_tag <= '0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               grant_tag <= '0;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Output register
   // --------------------------------------------------------------------------
   // A new beat may load in the same cycle the old beat drains (accept implies
   // out_ready). Without an accept, a drained beat clears valid. Data, tuser
   // and tlast change only on an accept, so they hold through a stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the wide data register is reset as well. Downstream logic
         // expects every output at zero during reset, and a beat held at reset
         // is dropped.
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tuser  <= '0;
         m_axis_tlast  <= 1'b0;
      end else if (accept) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= g_data;
         m_axis_tuser  <= grant_tag;
         m_axis_tlast  <= last_beat;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axis_tag_sched.sv
// -----------------------------------------------------------------------------
// tb_axis_tag_sched
//
// Directed bench for axis_tag_sched. A behavioural model tracks grants, burst
// beat counts and the output register with plain integers. It also keeps each
// tag's expected beat sequence number. Once per cycle, on the falling edge, one
// process compares every DUT output with that model. Directed scenarios add
// hand-computed literal expectations: beat order, tlast placement, idle gaps,
// the reset state, and a BURST_LEN=1 instance.
// -----------------------------------------------------------------------------
module tb_axis_tag_sched;

   localparam int NT = 20;
   localparam int DW = 256;
   localparam int BL = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NT-1:0]     tag_enable;
   logic [NT-1:0]     s_axis_tvalid;
   logic [NT-1:0]     s_axis_tready;
   logic [NT*DW-1:0]  s_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic [DW-1:0]     m_axis_tdata;
   logic [NT-1:0]     m_axis_tuser;
   logic              m_axis_tlast;
   logic [NT-1:0]     grant_tag;

   // Second instance: 3 tags, 8-bit data, BURST_LEN=1.
   logic [2:0]  b1_en, b1_valid, b1_ready, b1_tuser, b1_grant;
   logic [23:0] b1_sdata;
   logic        b1_mvalid, b1_mready, b1_mlast;
   logic [7:0]  b1_mdata;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   axis_tag_sched #(.NUM_TAGS(NT), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
      .clk(clk), .rst_n(rst_n), .tag_enable(tag_enable),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tdata(s_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
      .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
      .grant_tag(grant_tag)
   );

   axis_tag_sched #(.NUM_TAGS(3), .DATA_WIDTH(8), .BURST_LEN(1)) dut_b1 (
      .clk(clk), .rst_n(rst_n), .tag_enable(b1_en),
      .s_axis_tvalid(b1_valid), .s_axis_tready(b1_ready),
      .s_axis_tdata(b1_sdata), .m_axis_tvalid(b1_mvalid),
      .m_axis_tready(b1_mready), .m_axis_tdata(b1_mdata),
      .m_axis_tuser(b1_tuser), .m_axis_tlast(b1_mlast),
      .grant_tag(b1_grant)
   );

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Beat content for sequence number 'seq' of tag 'tag'.
   function automatic logic [DW-1:0] mk_data(input int tag, input int seq);
      logic [DW-1:0] d;
      d = '0;
      d[15:0]     = 16'(seq);
      d[23:16]    = 8'(tag);
      d[127:96]   = 32'(seq * 7 + tag * 1000);
      d[DW-1 -: 16] = ~16'(seq);
      return d;
   endfunction

   // ---------------------------------------------------------------------------
   // Source side. Each tag presents its beats in order and advances to the next
   // beat after a handshake, which is sampled on the preceding falling edge.
   // ---------------------------------------------------------------------------
   int            src_seq [NT];
   logic [NT-1:0] hs = '0;

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NT; i++) begin
         if (hs[i]) src_seq[i]++;
         s_axis_tdata[i*DW +: DW] = mk_data(i, src_seq[i]);
      end
   end

   // ---------------------------------------------------------------------------
   // Behavioural model plus per-cycle comparison. The model state describes the
   // outputs that are visible now. The step at the end applies the rules for
   // the upcoming clock edge, using the inputs that are stable now.
   // ---------------------------------------------------------------------------
   int            m_g = -1;          // granted tag, -1 when idle
   int            m_ptr = NT - 1;
   int            m_cnt = 0;
   bit            m_valid = 0;
   logic [DW-1:0] m_data = '0;
   logic [NT-1:0] m_user = '0;
   bit            m_last = 0;
   int            m_seq [NT];

   int cyc = 0;
   int obs_tag [$];
   bit obs_last [$];
   int obs_cyc [$];
   int obs_seq [$];
   bit saw_g2 = 0;

   always @(negedge clk) begin
      logic [NT-1:0] exp_ready;
      logic [NT-1:0] exp_grant;
      logic [NT-1:0] req;
      bit            oready;
      int            idx;
      cyc++;
      if (!rst_n) begin
         m_g = -1; m_ptr = NT - 1; m_cnt = 0;
         m_valid = 0; m_data = '0; m_user = '0; m_last = 0;
      end
      oready    = !m_valid || m_axis_tready;
      exp_ready = '0;
      exp_grant = '0;
      if (m_g >= 0) begin
         exp_grant[m_g] = 1'b1;
         if (oready && tag_enable[m_g]) exp_ready[m_g] = 1'b1;
      end
      check("s_axis_tready", s_axis_tready, exp_ready);
      check("grant_tag", grant_tag, exp_grant);
      check("m_axis_tvalid", m_axis_tvalid, m_valid);
      if (m_valid || !rst_n) begin
         check("m_axis_tdata", m_axis_tdata, m_data);
         check("m_axis_tuser", m_axis_tuser, m_user);
         check("m_axis_tlast", m_axis_tlast, m_last);
      end

      hs = s_axis_tvalid & s_axis_tready;
      if (grant_tag[2]) saw_g2 = 1;
      if (m_axis_tvalid && m_axis_tready) begin
         idx = -1;
         for (int i = 0; i < NT; i++) if (m_axis_tuser[i]) idx = i;
         obs_tag.push_back(idx);
         obs_last.push_back(m_axis_tlast);
         obs_cyc.push_back(cyc);
         obs_seq.push_back(int'(m_axis_tdata[15:0]));
      end

      if (rst_n) begin
         req = s_axis_tvalid & tag_enable;
         if (m_g < 0) begin
            if (m_valid && m_axis_tready) m_valid = 0;
            if (req != '0) begin
               idx = m_ptr;
               for (int k = 1; k <= NT; k++) begin
                  idx = (m_ptr + k) % NT;
                  if (req[idx]) break;
               end
               m_g = idx; m_ptr = idx; m_cnt = 0;
            end
         end else if (s_axis_tvalid[m_g] && exp_ready[m_g]) begin
            m_data  = mk_data(m_g, m_seq[m_g]);
            m_seq[m_g]++;
            m_user  = '0;
            m_user[m_g] = 1'b1;
            m_last  = (m_cnt == BL - 1);
            m_valid = 1;
            m_cnt++;
            if (m_cnt == BL) m_g = -1;
         end else begin
            if (m_valid && m_axis_tready) m_valid = 0;
            if (oready) m_g = -1;       // output free but nothing to take: burst over
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
   endtask

   task automatic clear_obs();
      obs_tag.delete(); obs_last.delete(); obs_cyc.delete(); obs_seq.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before the bench completed");
      $fatal(1);
   end

   initial begin
      int j;
      int n2;
      tag_enable    = '1;
      s_axis_tvalid = '0;
      m_axis_tready = 1'b1;
      b1_en = 3'b111; b1_valid = 3'b000; b1_mready = 1'b1;
      b1_sdata = {8'h33, 8'h22, 8'h11};
      rst_n = 1'b0;

      // Reset state
      #1;
      check("rst m_axis_tvalid", m_axis_tvalid, 0);
      check("rst m_axis_tdata", m_axis_tdata, 0);
      check("rst m_axis_tuser", m_axis_tuser, 0);
      check("rst m_axis_tlast", m_axis_tlast, 0);
      check("rst grant_tag", grant_tag, 0);
      check("rst s_axis_tready", s_axis_tready, 0);
      tick(2);
      rst_n = 1'b1;

      // Single requester: tag 3
      clear_obs();
      s_axis_tvalid[3] = 1'b1;
      tick(14);
      s_axis_tvalid = '0;
      tick(3);
      check("t1 beat count", obs_tag.size(), 11);
      for (int b = 0; b < 8; b++) check("t1 tag", obs_tag[b], 3);
      check("t1 last b2", obs_last[2], 0);
      check("t1 last b3", obs_last[3], 1);
      check("t1 last b4", obs_last[4], 0);
      check("t1 last b7", obs_last[7], 1);
      check("t1 group span", obs_cyc[3] - obs_cyc[0], 3);
      check("t1 idle gap", obs_cyc[4] - obs_cyc[3], 2);
      check("t1 seq b0", obs_seq[0], 0);
      check("t1 seq b7", obs_seq[7], 7);

      // Fairness: all tags request
      do_reset();
      clear_obs();
      s_axis_tvalid = '1;
      tick(110);
      s_axis_tvalid = '0;
      tick(4);
      check("t2 enough beats", obs_tag.size() >= 84, 1);
      for (int g = 0; g < 21; g++) begin
         check("t2 grant order", obs_tag[4*g], g % NT);
         check("t2 group tlast", obs_last[4*g+3], 1);
      end

      // Backpressure mid-burst on tag 7
      do_reset();
      clear_obs();
      s_axis_tvalid[7] = 1'b1;
      tick(3);
      m_axis_tready = 1'b0;
      tick(1);
      check("t3 stall s_tready", s_axis_tready, 0);
      check("t3 stall m_tvalid", m_axis_tvalid, 1);
      check("t3 stall m_tlast", m_axis_tlast, 0);
      check("t3 stall m_tuser", m_axis_tuser, 1 << 7);
      tick(2);
      m_axis_tready = 1'b1;
      tick(2);
      s_axis_tvalid = '0;
      tick(4);
      check("t3 beat count", obs_tag.size(), 4);
      for (int b = 1; b < 4; b++) check("t3 seq step", obs_seq[b] - obs_seq[0], b);
      for (int b = 0; b < 4; b++) check("t3 tlast", obs_last[b], (b == 3));

      // Early termination of tag 5, tag 9 waiting
      do_reset();
      clear_obs();
      s_axis_tvalid[5] = 1'b1;
      s_axis_tvalid[9] = 1'b1;
      tick(3);
      s_axis_tvalid[5] = 1'b0;
      tick(1);
      check("t4 idle grant", grant_tag, 0);
      tick(1);
      check("t4 grant 9", grant_tag, 1 << 9);
      tick(8);
      s_axis_tvalid = '0;
      tick(4);
      check("t4 tag b0", obs_tag[0], 5);
      check("t4 tag b1", obs_tag[1], 5);
      check("t4 no tlast b0", obs_last[0], 0);
      check("t4 no tlast b1", obs_last[1], 0);
      check("t4 next tag", obs_tag[2], 9);
      check("t4 handover gap", obs_cyc[2] - obs_cyc[1], 3);

      // Masking of tag 2, then enabling it
      clear_obs();
      saw_g2 = 0;
      tag_enable[2]    = 1'b0;
      s_axis_tvalid[2] = 1'b1;
      s_axis_tvalid[4] = 1'b1;
      tick(12);
      n2 = 0;
      foreach (obs_tag[b]) if (obs_tag[b] == 2) n2++;
      check("t5 masked grant", saw_g2, 0);
      check("t5 masked beats", n2, 0);
      tag_enable[2] = 1'b1;
      tick(12);
      s_axis_tvalid = '0;
      tick(4);
      j = -1;
      for (int b = obs_tag.size() - 1; b >= 0; b--) if (obs_tag[b] == 2) j = b;
      check("t5 first tag2 beat", j, 12);
      check("t5 prev tag", obs_tag[11], 4);
      check("t5 prev tlast", obs_last[11], 1);

      // Asynchronous reset during a burst
      clear_obs();
      s_axis_tvalid = '1;
      tick(3);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6 m_tvalid", m_axis_tvalid, 0);
      check("t6 m_tdata", m_axis_tdata, 0);
      check("t6 m_tuser", m_axis_tuser, 0);
      check("t6 m_tlast", m_axis_tlast, 0);
      check("t6 grant_tag", grant_tag, 0);
      check("t6 s_tready", s_axis_tready, 0);
      tick(2);
      rst_n = 1'b1;
      clear_obs();
      tick(1);
      check("t6 first grant", grant_tag, 1);
      tick(3);
      check("t6 first beat tag", obs_tag[0], 0);
      s_axis_tvalid = '0;
      tick(4);

      // BURST_LEN=1 instance: tag 1 requests continuously
      b1_valid = 3'b010;
      tick(1);
      check("b1 grant c1", b1_grant, 3'b010);
      check("b1 mvalid c1", b1_mvalid, 0);
      tick(1);
      check("b1 grant c2", b1_grant, 3'b000);
      check("b1 mvalid c2", b1_mvalid, 1);
      check("b1 mlast c2", b1_mlast, 1);
      check("b1 mdata c2", b1_mdata, 8'h22);
      check("b1 tuser c2", b1_tuser, 3'b010);
      tick(1);
      check("b1 grant c3", b1_grant, 3'b010);
      check("b1 mvalid c3", b1_mvalid, 0);
      tick(1);
      check("b1 mvalid c4", b1_mvalid, 1);
      check("b1 mlast c4", b1_mlast, 1);
      b1_valid = 3'b000;
      tick(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axis_tag_sched.md
# axis_tag_sched

Round-robin burst scheduler that shares the single complex-magnitude datapath between NUM_TAGS per-tag AXI-stream requesters. It grants one tag at a time for a burst of up to BURST_LEN beats, then moves to the next requesting tag. It forwards the granted tag's beats through one registered output stage, with a one-hot channel tag on tuser. It sits between the per-tag correlator outputs and the serialized magnitude/peak pipeline, and replaces plain fan-in where per-tag fairness and burst framing are required.

## Interface
- NUM_TAGS, 20, number of requesting tags
- DATA_WIDTH, 256, beat width per tag
- BURST_LEN, 4, maximum beats per grant; legal range 1..256

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tag_enable  in  NUM_TAGS  per-tag enable mask; disabled tags are never granted
- s_axis_tvalid  in  NUM_TAGS  per-tag valid
- s_axis_tready  out  NUM_TAGS  per-tag ready; at most one bit high
- s_axis_tdata  in  NUM_TAGS*DATA_WIDTH  packed per-tag data; tag i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tdata  out  DATA_WIDTH  output data
- m_axis_tuser  out  NUM_TAGS  one-hot source tag of the current output beat
- m_axis_tlast  out  1  marks the BURST_LEN-th beat of a grant
- grant_tag  out  NUM_TAGS  one-hot current grant; all zero when idle

## Operation
- Request vector: req = s_axis_tvalid & tag_enable.
- Pointer ptr holds the index of the last granted tag. Reset value is NUM_TAGS-1, so tag 0 has first priority.
- Beat counter cnt is $clog2(BURST_LEN)+1 bits wide.
- Output stage: a single register. out_ready = !m_axis_tvalid || m_axis_tready.
- State IDLE:
  - No s_axis_tready is asserted.
  - If req is nonzero, grant the first set index scanning cyclically from ptr+1 (wrapping from NUM_TAGS-1 to 0).
  - On a grant: set grant_tag, set ptr to the granted index, clear cnt, go to BURST.
  - If req is zero, stay in IDLE.
- State BURST, with g as the granted index:
  - s_axis_tready[g] = out_ready && tag_enable[g]. All other tready bits are 0.
  - Accept condition: s_axis_tvalid[g] && s_axis_tready[g].
  - On accept: load the output register with the data of tag g, m_axis_tuser = grant_tag, m_axis_tlast = (cnt == BURST_LEN-1). Then cnt++.
  - Accept with cnt == BURST_LEN-1: go to IDLE and clear grant_tag.
  - Early end: out_ready high and (!s_axis_tvalid[g] or !tag_enable[g]) → go to IDLE, clear grant_tag, emit no tlast.
  - out_ready low: hold state and cnt. Early-end detection is suspended while the output is stalled.
- Output register:
  - When m_axis_tvalid && m_axis_tready and no new accept occurs, m_axis_tvalid falls.
  - A new accept may occur in the same cycle the old beat drains.
  - Data, tuser and tlast are stable while m_axis_tvalid && !m_axis_tready.
- tag_enable changes take effect at the next arbitration. Deasserting the enable of the granted tag ends the burst as described above.
- Reset: asynchronous on the falling edge of rst_n. It forces IDLE, ptr = NUM_TAGS-1, cnt = 0, and drives all outputs to 0 (s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, grant_tag). A beat held in the output register is discarded. Release is synchronous to clk.

## Timing
- Arbitration takes 1 cycle (the IDLE cycle). The first beat can be accepted on the cycle after the grant.
- Accept at cycle t → m_axis_tvalid high at t+1.
- Sustained throughput for a continuously requesting set is BURST_LEN beats per BURST_LEN+1 cycles.
- No combinational path from m_axis_tready to m_axis_tvalid or m_axis_tdata.
- A combinational path from m_axis_tready to s_axis_tready is allowed and required.
- With BURST_LEN=1: every beat carries tlast, and IDLE and BURST alternate.

## Test plan
- Single requester: tag 3 valid continuously, BURST_LEN=4, m_axis_tready=1. Expect repeating groups of 4 beats with tuser=1<<3 and tlast on the 4th beat, each group followed by one idle cycle. Data matches source order.
- Fairness: all 20 tags valid continuously. Grant order is 0,1,…,19,0 with 4 beats each. No tag is granted twice before every requester has been granted once.
- Backpressure: m_axis_tready low for 3 cycles mid-burst. Output data, tuser and tlast are held; s_axis_tready[g] is low; after release no beat is lost or duplicated; tlast still falls on beat 4.
- Early termination: tag 5 presents 2 beats then drops valid, while tag 9 is also requesting. Expect 2 beats with tuser=1<<5 and no tlast, one IDLE cycle, then a grant to tag 9.
- Masking: tag 2 is valid but tag_enable[2]=0. Tag 2 is never granted and s_axis_tready[2] stays 0. Setting tag_enable[2]=1 causes tag 2 to be granted in its cyclic turn.
- Async reset mid-burst: assert rst_n low between clock edges during beat 2. All outputs go to 0 immediately; after release with all tags valid, the first grant is tag 0.
